// File: rtl/dm_load_unit_pkg.sv
// Shared load-type encodings and alignment helper for the data-memory load path.
// Load-type codes sit alongside the store-path STOREwhb codes.
package dm_load_unit_pkg;

  localparam logic [2:0] LOADtype_LW  = 3'b000;
  localparam logic [2:0] LOADtype_LH  = 3'b001;
  localparam logic [2:0] LOADtype_LHU = 3'b010;
  localparam logic [2:0] LOADtype_LB  = 3'b011;
  localparam logic [2:0] LOADtype_LBU = 3'b100;

  // Undefined codes fall through to the word check, matching their LW behaviour.
  function automatic logic load_misaligned(input logic [2:0] ltype, input logic [1:0] addr);
    logic mis;
    case (ltype)
      LOADtype_LH, LOADtype_LHU: mis = addr[0];
      LOADtype_LB, LOADtype_LBU: mis = 1'b0;
      default:                   mis = (addr != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dm_load_unit_if.sv
// Request/response and memory read-port bundle for the load unit.
interface dm_load_unit_if #(
  parameter int unsigned ADDR_W = 9
) ();

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_type;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_dout;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic              rsp_err;

  modport slave (
    input  req_valid, req_addr, req_type, mem_dout, rsp_ready,
    output req_ready, mem_rd, mem_addr, rsp_valid, rsp_data, rsp_err
  );

  modport master (
    output req_valid, req_addr, req_type, mem_dout, rsp_ready,
    input  req_ready, mem_rd, mem_addr, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/dm_load_unit_extract.sv
// Little-endian byte/halfword/word selection with sign or zero extension.
// Purely combinational so the single-cycle datapath can reuse it.
module load_extract
  import dm_load_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  ltype,
  output logic [31:0] data
);

  logic [15:0] half;
  logic [7:0]  bsel;

  always_comb begin
    half = addr[1] ? word[31:16] : word[15:0];
    unique case (addr)
      2'd0: bsel = word[7:0];
      2'd1: bsel = word[15:8];
      2'd2: bsel = word[23:16];
      2'd3: bsel = word[31:24];
      default: bsel = word[7:0];
    endcase

    case (ltype)
      LOADtype_LH:  data = {{16{half[15]}}, half};
      LOADtype_LHU: data = {16'h0000, half};
      LOADtype_LB:  data = {{24{bsel[7]}}, bsel};
      LOADtype_LBU: data = {24'h000000, bsel};
      default:      data = word;
    endcase
  end

endmodule

// File: rtl/dm_load_unit.sv
// Load unit: accepts a byte-addressed load, reads the aligned word after RD_LAT wait
// cycles, and returns the extended result over a valid/ready response.
module dm_load_unit
  import dm_load_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned RD_LAT = 0
) (
  input logic            clk,
  input logic            rst,
  input logic            flush,
  dm_load_unit_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  localparam logic [3:0] LatInit = 4'(RD_LAT);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        type_q, type_d;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;
  logic [31:0]       ext_data;

  load_extract u_extract (
    .word  (bus.mem_dout),
    .addr  (addr_q[1:0]),
    .ltype (type_q),
    .data  (ext_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      type_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      type_q  <= type_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    type_d  = type_q;
    data_d  = data_q;
    err_d   = err_q;

    // flush wins over any handshake in the same cycle
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            addr_d = bus.req_addr;
            type_d = bus.req_type;
            if (load_misaligned(bus.req_type, bus.req_addr[1:0])) begin
              state_d = StDone;
              err_d   = 1'b1;
              data_d  = '0;
            end else begin
              state_d = StWait;
              cnt_d   = LatInit;
            end
          end
        end
        StWait: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            data_d  = ext_data;
            err_d   = 1'b0;
            state_d = StDone;
          end
        end
        StDone: begin
          if (bus.rsp_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    bus.req_ready = (state_q == StIdle);
    bus.mem_rd    = (state_q == StWait);
    bus.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    bus.rsp_valid = (state_q == StDone);
    bus.rsp_data  = data_q;
    bus.rsp_err   = err_q;
  end

endmodule

// File: doc/dm_load_unit.md
Name: dm_load_unit

Overview:
- Read-side companion to the data memory store path: accepts a load request (byte address + load type), fetches the aligned word from data memory, then extracts and sign/zero-extends the byte, halfword or word.
- Sits between the CPU MEM stage and the data memory read port.
- Uses a valid/ready request and response handshake with a configurable memory read latency, so the same block works with combinational or registered memory.

Parameters:
- ADDR_W, 9, byte-address width (matches the 128-word data memory).
- RD_LAT, 0, wait cycles between driving mem_addr and mem_dout being valid (0..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort; drops any in-flight or pending load.
- req_valid  in  1  load request valid.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_addr  in  ADDR_W  byte address.
- req_type  in  3  load type; LOADtype_* encoding.
- mem_rd  out  1  read strobe to data memory.
- mem_addr  out  ADDR_W  word-aligned byte address: {addr[ADDR_W-1:2], 2'b00}.
- mem_dout  in  32  word returned by data memory.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_data  out  32  extended load result.
- rsp_err  out  1  misaligned-address error flag for this response.

Behaviour:
- Reset values (async on rst=1): state IDLE, so req_ready=1. rsp_valid=0, rsp_data=0, rsp_err=0, mem_rd=0, mem_addr=0, wait counter=0, latched addr/type=0.
- States:
  - IDLE: req_ready=1.
  - WAIT: mem_rd=1; mem_addr held stable.
  - DONE: rsp_valid=1; rsp_data and rsp_err held stable.
- IDLE transitions, on req_valid&&req_ready: latch req_addr and req_type.
  - If misaligned: go to DONE with rsp_err=1, rsp_data=0. mem_rd never asserts for this request.
  - Misaligned means LW with addr[1:0]!=0, or LH/LHU with addr[0]!=0.
  - Otherwise: go to WAIT, counter=RD_LAT.
- WAIT: if counter!=0, decrement. If counter==0, capture mem_dout, apply extraction, go to DONE with rsp_err=0.
- Latency: rsp_valid rises RD_LAT+1 clock edges after the accepting edge. With RD_LAT=0 that is the next edge.
- DONE: on rsp_valid&&rsp_ready, go to IDLE. No new request is accepted in the same cycle, because req_ready=0 in DONE.
- Extraction is little-endian, consistent with the store path.
  - LW: the word.
  - LH/LHU: halfword mem_dout[16*addr[1] +: 16], sign-/zero-extended.
  - LB/LBU: byte mem_dout[8*addr[1:0] +: 8], sign-/zero-extended.
- Undefined req_type codes behave as LW, including the LW alignment check.
- flush=1 at a clock edge: next state IDLE, rsp_valid=0, mem_rd=0.
  - The dropped result is never presented.
  - flush has priority over any handshake in the same cycle.
- rst asserted in any state, including mid-WAIT: immediate return to reset values. No rsp_valid follows.
- mem_addr updates only on request acceptance; it is don't-care-stable outside WAIT.

Decomposition:
- Load-type constants go in ctrl_encode_def.v, alongside the STOREwhb codes:
  - LOADtype_LW=3'b000
  - LOADtype_LH=3'b001
  - LOADtype_LHU=3'b010
  - LOADtype_LB=3'b011
  - LOADtype_LBU=3'b100
- State encodings are local to the module.
- One combinational sub-module, load_extract: inputs word, addr[1:0], type; output the 32-bit extended value. It is reusable by the single-cycle datapath.

Test Plan:
- Preload word 0x10 = 0x8765F0A1, RD_LAT=0. LW @0x10 -> rsp_data=0x8765F0A1, rsp_err=0, rsp_valid exactly 1 edge after accept.
- Same word: LB @0x10 -> 0xFFFFFFA1; LBU @0x11 -> 0x000000F0; LB @0x13 -> 0xFFFFFF87; LH @0x12 -> 0xFFFF8765; LHU @0x10 -> 0x0000F0A1.
- Misaligned requests:
  - LW @0x12 -> rsp_err=1, rsp_data=0, mem_rd never high.
  - LH @0x11 -> rsp_err=1.
  - LB @0x13 -> rsp_err=0.
- RD_LAT=3, LW @0x10 -> mem_rd high for 4 cycles, rsp_valid 4 edges after accept, mem_addr=0x10 throughout.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data/rsp_err stable, req_ready=0, further req_valid ignored. Raise rsp_ready -> IDLE next edge, req_ready=1.
- Abort, RD_LAT=3:
  - Assert rst asynchronously mid-WAIT -> outputs at reset values immediately, no rsp_valid afterwards.
  - Repeat with flush -> IDLE next edge, no rsp_valid.
  - flush coincident with rsp_valid&&rsp_ready -> IDLE, no double handshake.
